// File: rtl/deosc_multi.sv
// Multi-channel deoscillator: synchronizes N raw levels and filters each one.
// Latency: MODE 0 changes out TIME+2 edges after a new level; MODE 1 changes on edge 3.
// Backpressure: none; a free-running 1 MHz pipeline with no stall or handshake.
module deosc_multi #(
   parameter int N    = 4,
   parameter int TIME = 1000,
   parameter int MODE = 0,
   parameter int INIT = 1
) (
   input  logic         clkus,
   input  logic         rst,
   input  logic [N-1:0] in,
   input  logic         clr,
   output logic [N-1:0] out,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall,
   output logic [7:0]   glitch_cnt
);

   localparam int            CW       = $clog2(TIME + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIME - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic          INIT_LVL = (INIT != 0);

   logic [N-1:0]  s1;
   logic [N-1:0]  s2;
   logic [CW-1:0] cnt     [N];
   logic [CW-1:0] cnt_nxt [N];
   logic [N-1:0]  chg;
   logic [N-1:0]  glitch;

   // Per-channel decision: whether out flips this edge, next counter value,
   // and whether a pending change was aborted (MODE 0 only).
   always_comb begin
      chg    = '0;
      glitch = '0;
      for (int i = 0; i < N; i++) begin
         cnt_nxt[i] = cnt[i];
         if (MODE == 0) begin
            // Symmetric: a new level must be seen TIME times in a row.
            if (s2[i] == out[i]) begin
               cnt_nxt[i] = '0;
               glitch[i]  = (cnt[i] != '0);
            end else if (cnt[i] == CNT_LAST) begin
               cnt_nxt[i] = '0;
               chg[i]     = 1'b1;
            end else begin
               cnt_nxt[i] = cnt[i] + CNT_ONE;
            end
         end else begin
            // Fast attack: follow immediately, then ignore input for TIME edges.
            if (cnt[i] != '0) begin
               cnt_nxt[i] = cnt[i] - CNT_ONE;
            end else if (s2[i] != out[i]) begin
               cnt_nxt[i] = CNT_LAST;
               chg[i]     = 1'b1;
            end
         end
      end
   end

   // Synchronizer, filtered levels, edge pulses and per-channel counters.
   always_ff @(posedge clkus) begin
      if (rst) begin
         s1   <= {N{INIT_LVL}};
         s2   <= {N{INIT_LVL}};
         out  <= {N{INIT_LVL}};
         rise <= '0;
         fall <= '0;
         for (int i = 0; i < N; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1   <= in;
         s2   <= s1;
         out  <= out ^ chg;
         rise <= chg & ~out;
         fall <= chg & out;
         for (int i = 0; i < N; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

   // Shared glitch counter: one step per edge with any aborted change, saturating.
   always_ff @(posedge clkus) begin
      if (rst || clr) begin
         glitch_cnt <= '0;
      end else if ((|glitch) && (glitch_cnt != 8'hFF)) begin
         glitch_cnt <= glitch_cnt + 8'd1;
      end
   end

endmodule

// File: doc/deosc_multi.md
DEOSC_MULTI -- requirements
Module: deosc_multi

Interface
REQ-001 Parameter N, default 4: number of independent input channels, 1..32.
REQ-002 Parameter TIME, default 1000: settle/lockout time in clkus cycles (1 us each), 2..65535.
REQ-003 Parameter MODE, default 0: 0 = symmetric deoscillation, 1 = fast-attack with lockout.
REQ-004 Parameter INIT, default 1: idle level of every channel after reset (IR receivers idle high).
REQ-005 clkus  input  1  single clock, 1 MHz; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in  input  N  raw asynchronous channel inputs.
REQ-008 clr  input  1  synchronous clear of glitch_cnt.
REQ-009 out  output  N  deoscillated channel levels, registered.
REQ-010 rise  output  N  one-cycle pulse when out[i] goes 0->1, registered.
REQ-011 fall  output  N  one-cycle pulse when out[i] goes 1->0, registered.
REQ-012 glitch_cnt  output  8  saturating count of rejected glitches (MODE 0 only).

Function
REQ-013 Each in[i] SHALL pass through a two-flop synchronizer; s[i] denotes the second stage output.
REQ-014 Each channel SHALL own a counter of width clog2(TIME+1); channels SHALL not interact except via glitch_cnt.
REQ-015 MODE 0: while s[i]==out[i], cnt[i] SHALL be 0.
REQ-016 MODE 0: while s[i]!=out[i], cnt[i] SHALL increment each edge; on the edge sampling the TIME-th consecutive differing value, out[i] <= s[i] and cnt[i] <= 0.
REQ-017 MODE 0 latency: counting the first edge sampling the new in level as edge 1, out[i] SHALL change on edge TIME+2; any input level held fewer than TIME cycles SHALL never reach out.
REQ-018 MODE 0 abort: an edge where s[i]==out[i] while cnt[i]!=0 is a glitch; cnt[i] <= 0.
REQ-019 glitch_cnt SHALL increment by exactly 1 on any edge with one or more glitches across all channels, saturating at 255.
REQ-020 clr SHALL set glitch_cnt to 0 on the next edge; clr coincident with a glitch SHALL yield 0.
REQ-021 MODE 1: when cnt[i]==0 and s[i]!=out[i], out[i] <= s[i] on that edge and cnt[i] <= TIME-1.
REQ-022 MODE 1: while cnt[i]!=0, cnt[i] SHALL decrement each edge and out[i] SHALL hold regardless of s[i]; consecutive out[i] changes are spaced at least TIME edges.
REQ-023 MODE 1 latency: out[i] SHALL change on edge 3 (same numbering as REQ-017) when not locked; glitch_cnt SHALL stay 0.
REQ-024 rise[i]/fall[i] SHALL assert on the same edge out[i] changes and deassert on the next edge; never both high.
REQ-025 Simultaneous changes on several channels SHALL each resolve independently in the same cycle.
REQ-026 Parameters are static; no runtime mode or TIME change.

Reset
REQ-027 With rst high at an edge: both synchronizer stages and out SHALL become {N{INIT}}; cnt, rise, fall and glitch_cnt SHALL become 0.
REQ-028 rst mid-count SHALL abandon pending changes without producing rise/fall pulses or a glitch increment.
REQ-029 rst SHALL take priority over clr and all channel activity.

Verification (N=2, TIME=4, INIT=1 unless stated)
REQ-030 Reset: rst high 2 edges -> out=2'b11, rise=fall=0, glitch_cnt=0.
REQ-031 MODE 0: in[0] 1->0 held -> out[0]=0 on edge 6; fall[0] high exactly that cycle; out[1] stays 1.
REQ-032 MODE 0: in[0] low 3 cycles then high -> out[0] stays 1, glitch_cnt=1; low 4 cycles -> out[0] falls, glitch_cnt unchanged.
REQ-033 MODE 0: 300 glitches -> glitch_cnt=255; clr coincident with a glitch -> glitch_cnt=0 next cycle.
REQ-034 MODE 1: in[0] 1->0 -> out[0]=0 on edge 3; in[0] back to 1 for 2 cycles -> ignored; held at 1 -> out[0]=1 exactly 4 edges after the fall.
REQ-035 MODE 0: rst asserted at cnt[0]=2 -> out=2'b11, no pulses, glitch_cnt=0; full TIME+2 latency required afterwards.
